// File: rtl/adder_checker.sv
// adder_checker: rebuilds the expected adder sum, delays it to match the adder, and compares it with each valid result.
// Latency: a compare happens LATENCY cycles after its operands are sampled, and every output is registered.
// Backpressure: none; it accepts one compare per cycle indefinitely. Build option: ADDER_CHECKER_HALT_EN (freeze after first mismatch).
module adder_checker #(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [WIDTH-1:0] result,
   input  logic             clear,
   output logic             active,
   output logic             error,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] err_count,
   output logic [WIDTH-1:0] first_op1,
   output logic [WIDTH-1:0] first_op2,
   output logic [WIDTH-1:0] first_result
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CHECK = 2'd1;
`ifdef ADDER_CHECKER_HALT_EN
   localparam logic [1:0] S_HALT  = 2'd2;
`endif

   // Expected-value pipeline. Stage LATENCY-1 lines up with the adder's current result.
   logic             vld_q [LATENCY];
   logic [WIDTH-1:0] exp_q [LATENCY];
   logic [WIDTH-1:0] p1_q  [LATENCY];
   logic [WIDTH-1:0] p2_q  [LATENCY];

   logic [1:0]       state_q, state_d;
   logic             active_q, active_d;
   logic             error_q, error_d;
   logic [CNT_W-1:0] pass_q, pass_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [WIDTH-1:0] f_op1_q, f_op1_d;
   logic [WIDTH-1:0] f_op2_q, f_op2_d;
   logic [WIDTH-1:0] f_res_q, f_res_d;

   logic             cmp_vld;
   logic             match;
   logic [WIDTH-1:0] sum;

   // The carry is dropped, so a wrapped sum counts as correct.
   assign sum = op1 + op2;

   // Shift operands, expected sum and valid bit. Reset or clear discards anything still in flight.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         for (int i = 0; i < LATENCY; i++) begin
            vld_q[i] <= 1'b0;
            exp_q[i] <= '0;
            p1_q[i]  <= '0;
            p2_q[i]  <= '0;
         end
      end else begin
         vld_q[0] <= enable;
         exp_q[0] <= sum;
         p1_q[0]  <= op1;
         p2_q[0]  <= op2;
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            exp_q[i] <= exp_q[i-1];
            p1_q[i]  <= p1_q[i-1];
            p2_q[i]  <= p2_q[i-1];
         end
      end
   end

   // Compare happens only for valid slots; after a halt, slots keep draining but are ignored.
`ifdef ADDER_CHECKER_HALT_EN
   assign cmp_vld = vld_q[LATENCY-1] && (state_q != S_HALT);
`else
   assign cmp_vld = vld_q[LATENCY-1];
`endif
   assign match = (exp_q[LATENCY-1] == result);

   // Next-state logic for the FSM, the saturating counters and the first-error capture.
   always_comb begin
      state_d = state_q;
      pass_d  = pass_q;
      err_d   = err_q;
      error_d = error_q;
      f_op1_d = f_op1_q;
      f_op2_d = f_op2_q;
      f_res_d = f_res_q;
      if (cmp_vld) begin
         state_d = S_CHECK;
         if (match) begin
            if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
         end else begin
            if (err_q != '1) err_d = err_q + CNT_W'(1);
            error_d = 1'b1;
            if (!error_q) begin
               f_op1_d = p1_q[LATENCY-1];
               f_op2_d = p2_q[LATENCY-1];
               f_res_d = result;
            end
`ifdef ADDER_CHECKER_HALT_EN
            state_d = S_HALT;
`endif
         end
      end
      active_d = (state_d == S_CHECK);
   end

   // Register the checker state. Reset and clear have the same effect.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         state_q  <= S_IDLE;
         active_q <= 1'b0;
         error_q  <= 1'b0;
         pass_q   <= '0;
         err_q    <= '0;
         f_op1_q  <= '0;
         f_op2_q  <= '0;
         f_res_q  <= '0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         error_q  <= error_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         f_op1_q  <= f_op1_d;
         f_op2_q  <= f_op2_d;
         f_res_q  <= f_res_d;
      end
   end

   assign active       = active_q;
   assign error        = error_q;
   assign pass_count   = pass_q;
   assign err_count    = err_q;
   assign first_op1    = f_op1_q;
   assign first_op2    = f_op2_q;
   assign first_result = f_res_q;

endmodule

// File: tb/tb_adder_checker.sv
// Testbench for adder_checker. Instance A: WIDTH=4, LATENCY=1. Instance B: WIDTH=8, LATENCY=3, CNT_W=4.
// Each instance is driven by a behavioural adder that can flip bit0 of the sum on request.
// Expected counters are queued when stimulus is driven and checked when the result is due.
module tb_adder_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- instance A ----------------
   logic       en_a = 1'b0, clr_a = 1'b0, flt_a = 1'b0;
   logic [3:0] op1_a = '0, op2_a = '0, res_a = '0;
   logic       act_a, err_a;
   logic [15:0] pc_a, ec_a;
   logic [3:0] f1_a, f2_a, fr_a;

   // Adder with one cycle of latency. The fault flips bit0 only for 3+5.
   always @(posedge clk)
      res_a <= (op1_a + op2_a) ^ {3'b000, (flt_a && op1_a == 4'd3 && op2_a == 4'd5)};

   adder_checker #(.WIDTH(4), .LATENCY(1), .CNT_W(16)) dut_a (
      .clock(clk), .reset(rst), .enable(en_a), .op1(op1_a), .op2(op2_a),
      .result(res_a), .clear(clr_a), .active(act_a), .error(err_a),
      .pass_count(pc_a), .err_count(ec_a), .first_op1(f1_a), .first_op2(f2_a),
      .first_result(fr_a));

   // ---------------- instance B ----------------
   logic       en_b = 1'b0, clr_b = 1'b0, flt_b = 1'b0;
   logic [7:0] op1_b = '0, op2_b = '0, s1_b = '0, s2_b = '0, res_b = '0;
   logic       act_b, err_b;
   logic [3:0] pc_b, ec_b;
   logic [7:0] f1_b, f2_b, fr_b;

   // Adder with three cycles of latency. The fault flips bit0 of the sum.
   always @(posedge clk) begin
      s1_b  <= (op1_b + op2_b) ^ {7'd0, flt_b};
      s2_b  <= s1_b;
      res_b <= s2_b;
   end

   adder_checker #(.WIDTH(8), .LATENCY(3), .CNT_W(4)) dut_b (
      .clock(clk), .reset(rst), .enable(en_b), .op1(op1_b), .op2(op2_b),
      .result(res_b), .clear(clr_b), .active(act_b), .error(err_b),
      .pass_count(pc_b), .err_count(ec_b), .first_op1(f1_b), .first_op2(f2_b),
      .first_result(fr_b));

   // ---------------- scoreboard for instance A ----------------
   typedef struct {
      int due;
      int pass;
      int errc;
      bit error;
   } sb_item_t;
   sb_item_t sb[$];
   sb_item_t mon_it;

   always @(posedge clk) begin
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         mon_it = sb.pop_front();
         chk("sb_due_cycle", 32'(mon_it.due), 32'(cyc));
         chk("sb_pass_count", 32'(pc_a), 32'(mon_it.pass));
         chk("sb_err_count", 32'(ec_a), 32'(mon_it.errc));
         chk("sb_error", 32'(err_a), 32'(mon_it.error));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain_sb();
      for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      bit         flt;
      int         exp_pass;
      int         exp_err;
      bit         exp_error;
   } vec_t;

   function automatic logic [7:0] hop1(input int i);
      return 8'(i * 23 + 5);
   endfunction
   function automatic logic [7:0] hop2(input int i);
      return 8'(i * 41 + 7);
   endfunction

   initial begin
      vec_t tbl [8];
      bit   bub [6];
      int   n;
      logic [7:0] e_f1, e_f2, e_fr;

      tbl[0] = '{4'd3,  4'd5,  1'b0, 1, 0, 1'b0};
      tbl[1] = '{4'd15, 4'd1,  1'b0, 2, 0, 1'b0};
      tbl[2] = '{4'd7,  4'd7,  1'b0, 3, 0, 1'b0};
      tbl[3] = '{4'd0,  4'd0,  1'b0, 4, 0, 1'b0};
      tbl[4] = '{4'd9,  4'd12, 1'b0, 5, 0, 1'b0};
      tbl[5] = '{4'd8,  4'd8,  1'b0, 6, 0, 1'b0};
      tbl[6] = '{4'd15, 4'd15, 1'b0, 7, 0, 1'b0};
      tbl[7] = '{4'd3,  4'd5,  1'b1, 7, 1, 1'b1};
      bub = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      // Reset state.
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_active", 32'(act_a), 32'd0);
      chk("rst_error", 32'(err_a), 32'd0);
      chk("rst_pass", 32'(pc_a), 32'd0);
      chk("rst_err", 32'(ec_a), 32'd0);
      chk("rst_first_op1", 32'(f1_a), 32'd0);
      chk("rst_first_op2", 32'(f2_a), 32'd0);
      chk("rst_first_res", 32'(fr_a), 32'd0);
      chk("rst_b_pass", 32'(pc_b), 32'd0);

      // Exhaustive sweep on A. This includes 0xF+0x1, which wraps to 0x0.
      n = 0;
      en_a = 1'b1;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            op1_a = 4'(a);
            op2_a = 4'(b);
            n++;
            sb.push_back('{cyc + 2, n, 0, 1'b0});
            tick();
         end
      end
      en_a = 1'b0;
      drain_sb();
      chk("sweep_pass", 32'(pc_a), 32'd256);
      chk("sweep_err", 32'(ec_a), 32'd0);
      chk("sweep_error", 32'(err_a), 32'd0);
      chk("sweep_active", 32'(act_a), 32'd1);

      // Soft clear on A, followed by the table vectors. The last vector carries the 3+5 fault.
      clr_a = 1'b1; tick(); clr_a = 1'b0;
      chk("clr_a_pass", 32'(pc_a), 32'd0);
      chk("clr_a_active", 32'(act_a), 32'd0);
      en_a = 1'b1;
      for (int i = 0; i < 8; i++) begin
         op1_a = tbl[i].a;
         op2_a = tbl[i].b;
         flt_a = tbl[i].flt;
         sb.push_back('{cyc + 2, tbl[i].exp_pass, tbl[i].exp_err, tbl[i].exp_error});
         tick();
      end
      en_a = 1'b0;
      flt_a = 1'b0;
      drain_sb();
      chk("fault_first_op1", 32'(f1_a), 32'd3);
      chk("fault_first_op2", 32'(f2_a), 32'd5);
      chk("fault_first_res", 32'(fr_a), 32'd9);

      // Bubbles on B with LATENCY=3: only the four enabled slots are compared.
      for (int i = 0; i < 6; i++) begin
         en_b  = bub[i];
         op1_b = 8'(i * 17 + 200);
         op2_b = 8'(i * 9 + 60);
         tick();
      end
      en_b = 1'b0;
      repeat (5) tick();
      chk("bubble_pass", 32'(pc_b), 32'd4);
      chk("bubble_err", 32'(ec_b), 32'd0);
      chk("bubble_active", 32'(act_b), 32'd1);

      // Clear B with two transactions still in flight. Neither may be counted.
      en_b = 1'b1;
      op1_b = 8'd10; op2_b = 8'd20; tick();
      op1_b = 8'd30; op2_b = 8'd40; tick();
      en_b = 1'b0;
      clr_b = 1'b1; tick(); clr_b = 1'b0;
      chk("clr_b_pass_now", 32'(pc_b), 32'd0);
      chk("clr_b_active_now", 32'(act_b), 32'd0);
      repeat (5) tick();
      chk("clr_b_pass_later", 32'(pc_b), 32'd0);
      chk("clr_b_err_later", 32'(ec_b), 32'd0);
      chk("clr_b_active_later", 32'(act_b), 32'd0);

      // Saturation on B: 20 passing transactions with a 4-bit counter.
      en_b = 1'b1;
      for (int i = 0; i < 20; i++) begin
         op1_b = 8'(i * 13);
         op2_b = 8'(255 - i);
         tick();
      end
      en_b = 1'b0;
      repeat (5) tick();
      chk("sat_pass", 32'(pc_b), 32'hF);
      chk("sat_err", 32'(ec_b), 32'd0);

      // Two mismatches, five cycles apart, on B.
      clr_b = 1'b1; tick(); clr_b = 1'b0;
      en_b = 1'b1;
      for (int i = 0; i < 12; i++) begin
         op1_b = hop1(i);
         op2_b = hop2(i);
         flt_b = (i == 2 || i == 7);
         tick();
      end
      en_b = 1'b0;
      flt_b = 1'b0;
      repeat (5) tick();
      e_f1 = hop1(2);
      e_f2 = hop2(2);
      e_fr = (e_f1 + e_f2) ^ 8'd1;
      chk("halt_first_op1", 32'(f1_b), 32'(e_f1));
      chk("halt_first_op2", 32'(f2_b), 32'(e_f2));
      chk("halt_first_res", 32'(fr_b), 32'(e_fr));
      chk("halt_error", 32'(err_b), 32'd1);
`ifdef ADDER_CHECKER_HALT_EN
      chk("halt_err_count", 32'(ec_b), 32'd1);
      chk("halt_pass_count", 32'(pc_b), 32'd2);
      chk("halt_active", 32'(act_b), 32'd0);
`else
      chk("halt_err_count", 32'(ec_b), 32'd2);
      chk("halt_pass_count", 32'(pc_b), 32'd10);
      chk("halt_active", 32'(act_b), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t, expected it to finish", $time);
      $fatal(1);
   end

endmodule
